// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request/response bundle between clients and the shared adder arbiter
interface adder_share_arbiter_if;
  logic [1:0] req_valid, req_ready, req_cin, req_chain, req_more;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [7:0] rsp_sum;
  modport master (
    output req_valid, req_cin, req_chain, req_more, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum
  );
  modport slave (
    input req_valid, req_cin, req_chain, req_more, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cout, rsp_sum
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter for a shared 8-bit CLA with per-requester chained carry
// and one-entry response buffer; ADDER_ARB_LOCK_EN enables multi-beat grant locking via req_more.
module adder_share_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;
  logic acc;
  // each carry is unrolled into its own flat generate/propagate expression
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++) acc = g[j] | (p[j] & acc);
      c[i+1] = acc;
    end
    sum = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module adder_share_arbiter (
  input logic clk,
  input logic rst_n,
  adder_share_arbiter_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state;
  logic rr, sel, cin, slot_free, accept, cout, rsp_id, rsp_cout;
  logic [1:0] grant, carry_q;
  logic [7:0] a, b, sum, rsp_sum;
`ifdef ADDER_ARB_LOCK_EN
  logic locked, lock_id;
`endif
  always_comb begin
    grant = &bus.req_valid ? (rr ? 2'b10 : 2'b01) : bus.req_valid;
`ifdef ADDER_ARB_LOCK_EN
    if (locked) grant = bus.req_valid & (lock_id ? 2'b10 : 2'b01);
`endif
  end
  // reset gates ready so nothing looks accepted while the block is held in reset
  assign slot_free = rst_n & (state == EMPTY | bus.rsp_ready);
  assign bus.req_ready = grant & {2{slot_free}};
  assign accept = |bus.req_ready;
  assign sel = grant[1];
  assign a = sel ? bus.req_a1 : bus.req_a0;
  assign b = sel ? bus.req_b1 : bus.req_b0;
  assign cin = bus.req_chain[sel] ? carry_q[sel] : bus.req_cin[sel];
  adder_share_cla8 u_cla (.a(a), .b(b), .cin(cin), .sum(sum), .cout(cout));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      rr <= 1'b0;
      carry_q <= 2'b00;
      rsp_id <= 1'b0;
      rsp_sum <= 8'h00;
      rsp_cout <= 1'b0;
    end else if (accept) begin
      state <= FULL;
      rr <= ~sel;
      carry_q[sel] <= cout;
      rsp_id <= sel;
      rsp_sum <= sum;
      rsp_cout <= cout;
    end else if (bus.rsp_ready) begin
      state <= EMPTY;
    end
  end
`ifdef ADDER_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      lock_id <= 1'b0;
    end else if (accept) begin
      locked <= bus.req_more[sel];
      lock_id <= sel;
    end
  end
`endif
  assign bus.rsp_valid = state == FULL;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_sum = rsp_sum;
  assign bus.rsp_cout = rsp_cout;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed self-checking bench; rsp is compared as {valid,id,cout,sum}
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  adder_share_arbiter_if bus ();
  adder_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [10:0] rsp_now();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_cout, bus.rsp_sum};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 2'b00; bus.req_cin = 2'b00; bus.req_chain = 2'b00; bus.req_more = 2'b00;
    bus.req_a0 = 8'h00; bus.req_b0 = 8'h00; bus.req_a1 = 8'h00; bus.req_b1 = 8'h00;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 2'($urandom); bus.req_cin = 2'($urandom); bus.req_chain = 2'($urandom);
      bus.req_more = 2'($urandom); bus.rsp_ready = 1'($urandom);
      bus.req_a0 = 8'($urandom); bus.req_b0 = 8'($urandom); bus.req_a1 = 8'($urandom); bus.req_b1 = 8'($urandom);
      step();
      checks++;
      if (rsp_now() !== 11'h000) begin errors++; $display("FAIL reset_rsp got %h exp %h", rsp_now(), 11'h000); end
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", bus.req_ready); end
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b10; bus.req_a1 = 8'h10; bus.req_b1 = 8'h22; bus.req_cin = 2'b10;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL first_ready got %b exp 10", bus.req_ready); end
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b1, 1'b0, 8'h33}) begin errors++; $display("FAIL first_rsp got %h exp %h", rsp_now(), {1'b1, 1'b1, 1'b0, 8'h33}); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 2'b01; bus.req_a0 = 8'h7F; bus.req_b0 = 8'h01;
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b0, 1'b0, 8'h80}) begin errors++; $display("FAIL single got %h exp %h", rsp_now(), {1'b1, 1'b0, 1'b0, 8'h80}); end
    idle();
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL drain got %b exp 0", bus.rsp_valid); end
  endtask

  task automatic test_chain();
    do_reset();
    bus.req_valid = 2'b10; bus.req_a1 = 8'hFF; bus.req_b1 = 8'h01;
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b1, 1'b1, 8'h00}) begin errors++; $display("FAIL chain_lo got %h exp %h", rsp_now(), {1'b1, 1'b1, 1'b1, 8'h00}); end
    bus.req_a1 = 8'h00; bus.req_b1 = 8'h00; bus.req_chain = 2'b10;
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b1, 1'b0, 8'h01}) begin errors++; $display("FAIL chain_hi got %h exp %h", rsp_now(), {1'b1, 1'b1, 1'b0, 8'h01}); end
    idle();
  endtask

  task automatic test_contention();
    logic [10:0] exp [4];
    exp[0] = {1'b1, 1'b0, 1'b1, 8'h00};
    exp[1] = {1'b1, 1'b1, 1'b0, 8'h02};
    exp[2] = {1'b1, 1'b0, 1'b0, 8'h01};
    exp[3] = {1'b1, 1'b1, 1'b0, 8'h00};
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_a0 = 8'hFF; bus.req_b0 = 8'h01; bus.req_a1 = 8'h01; bus.req_b1 = 8'h01;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        bus.req_chain = 2'b11;
        bus.req_a0 = 8'h00; bus.req_b0 = 8'h00; bus.req_a1 = 8'h00; bus.req_b1 = 8'h00;
      end
      step();
      checks++;
      if (rsp_now() !== exp[k]) begin errors++; $display("FAIL contend%0d got %h exp %h", k, rsp_now(), exp[k]); end
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_valid = 2'b01; bus.req_a0 = 8'h05; bus.req_b0 = 8'h03;
    step();
    bus.rsp_ready = 1'b0; bus.req_valid = 2'b10; bus.req_a1 = 8'h20; bus.req_b1 = 8'h01;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready%0d got %b exp 00", k, bus.req_ready); end
      step();
      checks++;
      if (rsp_now() !== {1'b1, 1'b0, 1'b0, 8'h08}) begin errors++; $display("FAIL bp_hold%0d got %h exp %h", k, rsp_now(), {1'b1, 1'b0, 1'b0, 8'h08}); end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release got %b exp 10", bus.req_ready); end
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b1, 1'b0, 8'h21}) begin errors++; $display("FAIL bp_refill got %h exp %h", rsp_now(), {1'b1, 1'b1, 1'b0, 8'h21}); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_valid = 2'b01; bus.req_a0 = 8'hFF; bus.req_b0 = 8'h01;
    step();
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_now() !== 11'h000) begin errors++; $display("FAIL async_rst got %h exp %h", rsp_now(), 11'h000); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1; bus.req_valid = 2'b01; bus.req_chain = 2'b01; bus.req_a0 = 8'h00; bus.req_b0 = 8'h00;
    step();
    checks++;
    if (rsp_now() !== {1'b1, 1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL carry_cleared got %h exp %h", rsp_now(), {1'b1, 1'b0, 1'b0, 8'h00}); end
    idle();
  endtask

  task automatic test_lock();
    logic [3:0] exp_ids;
    logic [1:0] exp_rdy;
    logic [1:0] more_seq [4];
`ifdef ADDER_ARB_LOCK_EN
    exp_ids = 4'b1000;
    exp_rdy = 2'b01;
`else
    exp_ids = 4'b1010;
    exp_rdy = 2'b10;
`endif
    more_seq[0] = 2'b01; more_seq[1] = 2'b01; more_seq[2] = 2'b00; more_seq[3] = 2'b00;
    do_reset();
    bus.req_valid = 2'b11; bus.req_a0 = 8'h01; bus.req_a1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      bus.req_more = more_seq[k];
      #1;
      if (k == 1) begin
        checks++;
        if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL lock_ready got %b exp %b", bus.req_ready, exp_rdy); end
      end
      step();
      checks++;
      if (rsp_now() !== {1'b1, exp_ids[k], 1'b0, exp_ids[k] ? 8'h02 : 8'h01}) begin
        errors++; $display("FAIL lock_beat%0d got %h exp %h", k, rsp_now(), {1'b1, exp_ids[k], 1'b0, exp_ids[k] ? 8'h02 : 8'h01});
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_chain();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
